// File: rtl/dispatch_unit.sv
// dispatch_unit: dual-issue in-order dispatcher with register renaming.
// Decodes two instructions per cycle, allocates reservation stations, renames
// register operands through a status table, and publishes each issued
// instruction on a registered, tri-stated instruction bus for one cycle.
module dispatch_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst1,
  input  logic [31:0] inst2,
  input  logic [1:0]  inst_valid,
  output logic [1:0]  inst_accept,
  input  logic [39:0] loadbus,
  input  logic [39:0] multbus,
  input  logic [39:0] addbus,
  input  logic [7:0]  st_done_tag,
  input  logic        st_done_valid,
  output logic [39:0] instbus1,
  output logic [39:0] instbus2,
  output logic [8:0]  busy
);

  localparam logic [7:0] OP_LOAD  = 8'h01;
  localparam logic [7:0] OP_STORE = 8'h02;
  localparam logic [7:0] OP_ADD   = 8'h03;
  localparam logic [7:0] OP_MULTI = 8'h04;

  // Station tags indexed by busy bit position {ST1,ST0,LD1,LD0,M1,M0,A2,A1,A0}
  localparam logic [8:0][7:0] STN_TAG  = {8'h51, 8'h50, 8'h41, 8'h40, 8'h31,
                                          8'h30, 8'h22, 8'h21, 8'h20};
  localparam logic [3:0][7:0] REG_CODE = {8'h13, 8'h12, 8'h11, 8'h10};

  logic [8:0]       busy_q, busy_d;
  logic [3:0][7:0]  tbl_q, tbl_d;
  logic             bus1_vld_q, bus1_vld_d, bus2_vld_q, bus2_vld_d;
  logic [39:0]      bus1_q, bus1_d, bus2_q, bus2_d;

  logic [8:0][7:0]  bcast_tag_s;
  logic [8:0]       bcast_en_s;
  logic [8:0]       clr_s;
  logic [3:0]       tbl_hit_s;

  logic [7:0]       op1_s, op2_s, dst1_s, dst2_s;
  logic [8:0]       mask1_s, mask2_s, grant1_s, grant2_s;
  logic             known1_s, known2_s, acc1_s, acc2_s, wr1_s, wr2_s;
  logic [7:0]       tag1_s, tag2_s;
  logic [7:0]       s11_s, s12_s, d1r_s, s21_s, s22_s, d2r_s;
  logic             unused_data_s;

  // Station class of an opcode as a mask over the busy vector
  function automatic logic [8:0] class_mask(input logic [7:0] op);
    case (op)
      OP_ADD:   class_mask = 9'h007;
      OP_MULTI: class_mask = 9'h018;
      OP_LOAD:  class_mask = 9'h060;
      OP_STORE: class_mask = 9'h180;
      default:  class_mask = 9'h000;
    endcase
  endfunction

  // Isolate the lowest set bit (lowest-numbered free station)
  function automatic logic [8:0] pick_lowest(input logic [8:0] free);
    pick_lowest = free & (~free + 9'h001);
  endfunction

  // Tag of a one-hot station grant (zero when no grant)
  function automatic logic [7:0] onehot_tag(input logic [8:0] oh);
    onehot_tag = 8'h00;
    for (int i = 32'sd0; i < 32'sd9; i++) begin
      onehot_tag = onehot_tag | (oh[i] ? STN_TAG[i] : 8'h00);
    end
  endfunction

  function automatic logic is_reg(input logic [7:0] code);
    is_reg = (code[7:2] == 6'b000100);
  endfunction

  // Table lookup; a register whose producer broadcasts this cycle reads as ready
  function automatic logic [7:0] rename(input logic [7:0]      code,
                                        input logic [3:0][7:0] tbl,
                                        input logic [3:0]      hit);
    if (!is_reg(code)) begin
      rename = code;
    end else if (hit[code[1:0]]) begin
      rename = code;
    end else begin
      rename = tbl[code[1:0]];
    end
  endfunction

  // Broadcast tag seen by each station: A from addbus, M from multbus, LD from loadbus, ST from st_done
  assign bcast_tag_s = {st_done_tag, st_done_tag, loadbus[39:32], loadbus[39:32],
                        multbus[39:32], multbus[39:32],
                        addbus[39:32], addbus[39:32], addbus[39:32]};
  assign bcast_en_s  = {st_done_valid, st_done_valid, 7'h7F};

  // Payload data is not needed for dispatch decisions
  assign unused_data_s = ^{loadbus[31:0], multbus[31:0], addbus[31:0]};

  // Stations retiring at this edge; unknown or idle-station tags are ignored
  always_comb begin
    clr_s = 9'h000;
    for (int i = 32'sd0; i < 32'sd9; i++) begin
      if (busy_q[i] && bcast_en_s[i] && (bcast_tag_s[i] == STN_TAG[i])) begin
        clr_s[i] = 1'b1;
      end else begin
        clr_s[i] = 1'b0;
      end
    end
  end

  // Table entries whose producer broadcasts this cycle
  always_comb begin
    tbl_hit_s = 4'h0;
    for (int r = 32'sd0; r < 32'sd4; r++) begin
      for (int i = 32'sd0; i < 32'sd9; i++) begin
        if (clr_s[i] && (tbl_q[r] == STN_TAG[i])) begin
          tbl_hit_s[r] = 1'b1;
        end else begin
          tbl_hit_s[r] = tbl_hit_s[r];
        end
      end
    end
  end

  // Decode, allocate and rename both instructions in program order
  always_comb begin
    op1_s    = inst1[31:24];
    op2_s    = inst2[31:24];
    dst1_s   = inst1[7:0];
    dst2_s   = inst2[7:0];
    mask1_s  = class_mask(op1_s);
    mask2_s  = class_mask(op2_s);
    known1_s = |mask1_s;
    known2_s = |mask2_s;

    grant1_s = pick_lowest(mask1_s & ~busy_q);
    if (rst) begin
      acc1_s = 1'b0;
    end else if (inst_valid[0] && (!known1_s || (grant1_s != 9'h000))) begin
      acc1_s = 1'b1;
    end else begin
      acc1_s = 1'b0;
    end
    tag1_s = onehot_tag(grant1_s);
    wr1_s  = acc1_s && known1_s && (op1_s != OP_STORE) && is_reg(dst1_s);

    // inst2 sees the free set left after inst1 has taken its station
    grant2_s = pick_lowest(mask2_s & ~busy_q & ~(acc1_s ? grant1_s : 9'h000));
    if (acc1_s && inst_valid[1] && (!known2_s || (grant2_s != 9'h000))) begin
      acc2_s = 1'b1;
    end else begin
      acc2_s = 1'b0;
    end
    tag2_s = onehot_tag(grant2_s);
    wr2_s  = acc2_s && known2_s && (op2_s != OP_STORE) && is_reg(dst2_s);

    s11_s = rename(inst1[23:16], tbl_q, tbl_hit_s);
    s12_s = rename(inst1[15:8],  tbl_q, tbl_hit_s);
    d1r_s = (op1_s == OP_STORE) ? rename(dst1_s, tbl_q, tbl_hit_s) : dst1_s;

    // inst2 operands produced by inst1 come straight from inst1's station
    s21_s = (wr1_s && (inst2[23:16] == dst1_s)) ? tag1_s
                                                : rename(inst2[23:16], tbl_q, tbl_hit_s);
    s22_s = (wr1_s && (inst2[15:8] == dst1_s))  ? tag1_s
                                                : rename(inst2[15:8], tbl_q, tbl_hit_s);
    if (op2_s == OP_STORE) begin
      d2r_s = (wr1_s && (dst2_s == dst1_s)) ? tag1_s : rename(dst2_s, tbl_q, tbl_hit_s);
    end else begin
      d2r_s = dst2_s;
    end
  end

  // Next state: busy flags, rename table (issue beats retire, inst2 beats inst1) and issue slots
  always_comb begin
    busy_d = (busy_q & ~clr_s) | (acc1_s ? grant1_s : 9'h000) | (acc2_s ? grant2_s : 9'h000);
    for (int r = 32'sd0; r < 32'sd4; r++) begin
      if (wr2_s && (dst2_s[1:0] == r[1:0])) begin
        tbl_d[r] = tag2_s;
      end else if (wr1_s && (dst1_s[1:0] == r[1:0])) begin
        tbl_d[r] = tag1_s;
      end else if (tbl_hit_s[r]) begin
        tbl_d[r] = REG_CODE[r];
      end else begin
        tbl_d[r] = tbl_q[r];
      end
    end
    bus1_vld_d = acc1_s && known1_s;
    bus2_vld_d = acc2_s && known2_s;
    bus1_d     = {tag1_s, op1_s, s11_s, s12_s, d1r_s};
    bus2_d     = {tag2_s, op2_s, s21_s, s22_s, d2r_s};
  end

  // State registers; reset discards any pending issue immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q     <= 9'h000;
      tbl_q      <= REG_CODE;
      bus1_vld_q <= 1'b0;
      bus2_vld_q <= 1'b0;
      bus1_q     <= 40'h00_0000_0000;
      bus2_q     <= 40'h00_0000_0000;
    end else begin
      busy_q     <= busy_d;
      tbl_q      <= tbl_d;
      bus1_vld_q <= bus1_vld_d;
      bus2_vld_q <= bus2_vld_d;
      bus1_q     <= bus1_d;
      bus2_q     <= bus2_d;
    end
  end

  assign inst_accept = {acc2_s, acc1_s};
  assign busy        = busy_q;
  assign instbus1    = bus1_vld_q ? bus1_q : {40{1'bz}};
  assign instbus2    = bus2_vld_q ? bus2_q : {40{1'bz}};

endmodule

// File: doc/dispatch_unit.md
DISPATCH_UNIT -- requirements
Module: dispatch_unit

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have ports: rst  in  1  asynchronous, active-high reset.
REQ-003 SHALL have ports: inst1, inst2  in  32 each  raw instruction {op[31:24], src1[23:16], src2[15:8], dest[7:0]}; inst1 is older.
REQ-004 SHALL have ports: inst_valid  in  2  bit0 qualifies inst1, bit1 qualifies inst2.
REQ-005 SHALL have ports: inst_accept  out  2  combinational; bit0 means inst1 taken this edge, bit1 means inst2 taken this edge.
REQ-006 SHALL have ports: loadbus, multbus, addbus  in  40 each  result broadcast {tag[39:32], data[31:0]}.
REQ-007 SHALL have ports: st_done_tag  in  8  ST0/ST1 tag being retired; st_done_valid  in  1  qualifies it.
REQ-008 SHALL have ports: instbus1, instbus2  out  40 each  registered issue {station[39:32], op[31:24], src1[23:16], src2[15:8], dest[7:0]}; driven all-z when idle.
REQ-009 SHALL have ports: busy  out  9  station busy flags {ST1,ST0,LD1,LD0,M1,M0,A2,A1,A0}.
REQ-010 SHALL use these codes: LOAD 01, STORE 02, ADD 03, MULTI 04; R0-R3 10-13; A0-A2 20-22; M0-M1 30-31; LD0-LD1 40-41; ST0-ST1 50-51 (hex).

Function
REQ-011 SHALL keep a register status table, one 8-bit entry per R0-R3; an entry holds either the register's own code (value ready) or the producing station tag.
REQ-012 SHALL map op to station class: ADD to A0-A2, MULTI to M0-M1, LOAD to LD0-LD1, STORE to ST0-ST1; allocation SHALL pick the lowest-numbered free station.
REQ-013 SHALL accept inst1 when inst_valid[0]=1 and a station of its class is free.
REQ-014 SHALL accept inst2 only when inst1 is accepted, inst_valid[1]=1, and a station of its class is free after inst1's allocation; issue is strictly in order.
REQ-015 SHALL allocate two distinct stations when both instructions need the same class.
REQ-016 SHALL treat an unknown op as accepted and discarded: no station allocated, no table update, and its instbus slot z.
REQ-017 SHALL rename each src field in the range R0-R3 to the current table entry; any other src code SHALL pass through unchanged.
REQ-018 SHALL forward within a pair: an inst2 src equal to inst1's dest SHALL take inst1's allocated station tag.
REQ-019 SHALL emit a src as the plain R-code when its table entry equals the tag on addbus, multbus or loadbus in the same cycle; the value is written back at that edge.
REQ-020 SHALL set the dest table entry to the allocated station tag on issue; if both instructions name the same dest, inst2's tag wins.
REQ-021 SHALL treat STORE dest as a source operand: it renames like a src field and updates no table entry.
REQ-022 SHALL, for each CDB broadcast, clear the table entries equal to that tag back to their own R-code; a same-edge issue rename of that register SHALL override the clear.
REQ-023 SHALL clear the busy bit of a station when a broadcast matches its tag (addbus for A, multbus for M, loadbus for LD) or when st_done_valid=1 and st_done_tag matches (ST).
REQ-024 SHALL NOT make a station freed at an edge allocatable until the following cycle; allocation uses registered busy only.
REQ-025 SHALL register the issue: instbus1/instbus2 carry the accepted instruction in the cycle after the accepting edge, for exactly one cycle; inst1 always appears on instbus1.
REQ-026 SHALL ignore bus tags containing x/z or matching no busy station.
REQ-027 SHALL, when all stations of inst1's class are busy, drive inst_accept=00 and both instbus outputs z in the next cycle.

Reset
REQ-028 SHALL, while rst=1: busy=0, table entries = R0..R3 own codes, instbus1/instbus2 = z, inst_accept=00, independent of clk.
REQ-029 SHALL discard any in-flight issue when reset asserts mid-operation; the first accept after rst deasserts SHALL occur no earlier than the first rising edge with rst=0.

Verification
REQ-030 SHALL cover dual ADD: inst1=03_12_13_10, inst2=03_10_11_12 -> next cycle instbus1=20_03_12_13_10, instbus2=21_03_20_11_12, busy=0x003.
REQ-031 SHALL cover class exhaustion: A0-A2 busy, ADD valid -> inst_accept=00; addbus=21_00000005 -> next cycle accept=01 and the ADD issues to A1.
REQ-032 SHALL cover partial accept: LD0/LD1 busy, inst1=ADD, inst2=LOAD -> inst_accept=01, only instbus1 driven, instbus2 z.
REQ-033 SHALL cover same-cycle bypass: R1 mapped to M0, multbus=30_CCCCCCCC while ADD src R1 dispatches -> src field = 11 and R1 entry returns to 11.
REQ-034 SHALL cover store retirement: STORE issues to ST0, st_done_valid=1 with tag 50 -> busy[7] clears and ST0 is reallocated the next cycle.
REQ-035 SHALL cover reset mid-operation: rst pulsed with 3 stations busy and R2 renamed -> busy=0, R2 entry=12, buses z before the next clk edge.
